regfile_sb: RTL

- Parametrised successor to the core's integer register file.
- Adds configurable data width and depth, and optional hardwired zero register.
- Adds asynchronous clear of architectural state and write-to-read bypass.
- Adds a per-register pending (scoreboard) bit so the decode stage can detect RAW hazards against in-flight producers.
- Sits between decode (reads, issue marking) and writeback (write, pending clear).

---
 rtl/regfile_sb.sv | 65 ++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-to-read bypass and per-register pending scoreboard
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            iss,
    input  logic [AW-1:0]   ia,
    input  logic            flush,
    output logic            any_busy
);
    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic             wr_ok;
    logic             z1;
    logic             z2;
    logic             fwd1;
    logic             fwd2;

    assign wr_ok = we && !(ZERO_REG != 0 && wa == '0);
    assign z1    = ZERO_REG != 0 && ra1 == '0;
    assign z2    = ZERO_REG != 0 && ra2 == '0;
    assign fwd1  = BYPASS != 0 && we && wa == ra1;
    assign fwd2  = BYPASS != 0 && we && wa == ra2;

    // later assignments win: flush over issue over writeback clear
    always_comb begin
        pend_nxt = pend;
        if (we) pend_nxt[wa] = 1'b0;
        if (iss) pend_nxt[ia] = 1'b1;
        if (flush) pend_nxt = '0;
        if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            pend <= '0;
        end else begin
            if (wr_ok) mem[wa] <= wd;
            pend <= pend_nxt;
        end
    end

    // outputs are forced quiet while reset is held, including the bypass path
    assign rd1      = (!rst_n || z1) ? '0 : fwd1 ? wd : mem[ra1];
    assign rd2      = (!rst_n || z2) ? '0 : fwd2 ? wd : mem[ra2];
    assign busy1    = rst_n && !z1 && !fwd1 && pend[ra1];
    assign busy2    = rst_n && !z2 && !fwd2 && pend[ra2];
    assign any_busy = rst_n && |pend;
endmodule
